// File: rtl/rt_pkg.sv
// Shared constants, widths and state encoding for the ray-trace frame scheduler.
package rt_pkg;

    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int ADDR_W  = 19;
    localparam int PIX_W   = 4;
    localparam int TIMEOUT = 4096;

    localparam logic [PIX_W-1:0] ERR_PIX = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } sched_state_t;

endpackage

// File: rtl/rt_frame_scheduler_if.sv
// Core request/result bundle and framebuffer write bundle.
interface rt_core_if;
    import rt_pkg::*;

    logic             enable;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic             ready;
    logic [PIX_W-1:0] pixel;

    modport master (output enable, x, y, input ready, pixel);
    modport slave  (input enable, x, y, output ready, pixel);
endinterface

interface rt_fb_if;
    import rt_pkg::*;

    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;

    modport master (output we, addr, data);
    modport slave  (input we, addr, data);
endinterface

// File: rtl/rt_pixel_counter.sv
// Raster X/Y counter with an incrementally maintained linear address.
module rt_pixel_counter
    import rt_pkg::*;
#(
    parameter int H_RES = rt_pkg::H_RES,
    parameter int V_RES = rt_pkg::V_RES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              advance,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic x_end;
    logic y_end;

    assign x_end = (x == X_W'(H_RES - 1));
    assign y_end = (y == Y_W'(V_RES - 1));
    assign last  = x_end && y_end;

    // Address steps by one per pixel, so it tracks y*H_RES+x without a multiply.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (clear) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (advance) begin
            addr <= addr + 1'b1;
            if (x_end) begin
                x <= '0;
                y <= y_end ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rt_frame_scheduler.sv
// Walks a frame pixel by pixel: issue to RTcore, wait for result, write framebuffer.
module rt_frame_scheduler
    import rt_pkg::*;
#(
    parameter int H_RES   = rt_pkg::H_RES,
    parameter int V_RES   = rt_pkg::V_RES,
    parameter int TIMEOUT = rt_pkg::TIMEOUT
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   start,
    input  logic   abort,
    input  logic   continuous,
    rt_core_if.master core,
    rt_fb_if.master   fb,
    output logic   busy,
    output logic   frame_done,
    output logic   err
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic              ready_q;
    logic              accept;
    logic              expired;
    logic              clear;
    logic              advance;
    logic              last;
    logic [TW-1:0]     wait_cnt;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] addr;

    rt_pixel_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .advance (advance),
        .x       (x),
        .y       (y),
        .addr    (addr),
        .last    (last)
    );

    assign core.x = x;
    assign core.y = y;

    // Only a fresh rising edge counts, so a READY left high is never reused.
    assign accept  = core.ready && !ready_q;
    assign expired = (wait_cnt == TW'(TIMEOUT - 1));
    assign clear   = abort || (state == IDLE) || (state == DONE);
    assign advance = !abort && (state == WRITE) && !last;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (accept || expired) state_nxt = WRITE;
            WRITE:   state_nxt = last ? DONE : ISSUE;
            DONE:    state_nxt = continuous ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Strobes are decoded from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ready_q     <= 1'b0;
            wait_cnt    <= '0;
            core.enable <= 1'b0;
            fb.we       <= 1'b0;
            fb.addr     <= '0;
            fb.data     <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            ready_q     <= core.ready;
            core.enable <= (state_nxt == ISSUE);
            fb.we       <= (state_nxt == WRITE);
            frame_done  <= (state_nxt == DONE);
            busy        <= (state_nxt != IDLE);

            if ((state == WAIT) && (state_nxt == WAIT))
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;

            if ((state == WAIT) && (state_nxt == WRITE)) begin
                fb.addr <= addr;
                fb.data <= accept ? core.pixel : ERR_PIX;
            end

            if ((state == IDLE) && (state_nxt == ISSUE))
                err <= 1'b0;
            else if ((state == WAIT) && (state_nxt == WRITE) && !accept)
                err <= 1'b1;
        end
    end

endmodule
